// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared block geometry, token field widths and coefficient expander state encoding
package jpeg_pkg;
  localparam int BLK_LEN = 64;
  localparam int IDX_W = $clog2(BLK_LEN);
  localparam int TOKEN_RUN_W = 6;
  localparam int TOKEN_VAL_W = 8;
  localparam int MARKER_POS_W = 7;
  typedef enum logic [1:0] {IDLE, ZEROS, VALUE, FILL} state_t;
endpackage

// File: rtl/coef_run_expander.sv
// coef_run_expander: expands run/value tokens into indexed coefficients; optional err_overflow via COEF_EXP_ERR_EN
module coef_run_expander #(
  parameter int BLK_LEN = jpeg_pkg::BLK_LEN,
  parameter int DATA_W = jpeg_pkg::TOKEN_VAL_W,
  localparam int IDX_W = $clog2(BLK_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_size,
  input  logic [DATA_W-1:0] in_val,
  input  logic [6:0]        in_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_coef,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
`ifdef COEF_EXP_ERR_EN
  output logic              err_overflow,
`endif
  output logic              marker_valid,
  output logic [6:0]        marker_pos
);
  import jpeg_pkg::*;
  state_t state, n_state;
  logic [6:0] zcnt, n_zcnt, z;
  logic [DATA_W-1:0] val, n_val, n_coef;
  logic [IDX_W-1:0] n_idx;
  logic [6:0] n_mpos;
  logic n_valid, n_mv, err, n_err, take, fire;
  assign take = in_valid & in_ready;
  assign fire = out_valid & out_ready;
  assign z = in_size[9:3] - 7'd1;
  assign out_last = out_idx == IDX_W'(BLK_LEN - 1);
`ifdef COEF_EXP_ERR_EN
  assign err_overflow = err;
`endif
  // next-state and next-beat decode; out_idx doubles as the block index counter
  always_comb begin
    n_state = state;
    n_zcnt = zcnt;
    n_val = val;
    n_valid = out_valid;
    n_coef = out_coef;
    n_idx = fire ? out_idx + 1'b1 : out_idx;
    n_mv = 1'b0;
    n_mpos = marker_pos;
    n_err = err;
    case (state)
      IDLE: if (take) begin
        if (in_size[9:3] == 7'd0) begin
          if (in_flag != 7'd0) begin
            n_mv = 1'b1;
            n_mpos = in_flag;
            n_idx = '0;
            n_err = err | (out_idx != '0);
          end else if (out_idx != '0) begin
            n_state = FILL;
            n_valid = 1'b1;
            n_coef = '0;
          end
        end else begin
          n_val = in_val;
          n_zcnt = z;
          n_valid = 1'b1;
          n_state = z == 7'd0 ? VALUE : ZEROS;
          n_coef = z == 7'd0 ? in_val : '0;
        end
      end
      ZEROS: if (fire) begin
        n_zcnt = zcnt - 7'd1;
        if (out_last) begin
          n_state = IDLE;
          n_valid = 1'b0;
          n_err = 1'b1;
        end else if (zcnt == 7'd1) begin
          n_state = VALUE;
          n_coef = val;
        end
      end
      VALUE: if (fire) begin
        n_state = IDLE;
        n_valid = 1'b0;
      end
      FILL: if (fire && out_last) begin
        n_state = IDLE;
        n_valid = 1'b0;
      end
      default: n_state = IDLE;
    endcase
  end
  // state and registered outputs; reset abandons any beat in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      zcnt <= '0;
      val <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_coef <= '0;
      out_idx <= '0;
      marker_valid <= 1'b0;
      marker_pos <= '0;
      err <= 1'b0;
    end else begin
      state <= n_state;
      zcnt <= n_zcnt;
      val <= n_val;
      in_ready <= n_state == IDLE;
      out_valid <= n_valid;
      out_coef <= n_coef;
      out_idx <= n_idx;
      marker_valid <= n_mv;
      marker_pos <= n_mpos;
      err <= n_err;
    end
  end
endmodule

// File: tb/tb_coef_run_expander.sv
// tb_coef_run_expander: token-level expansion model with per-beat scoreboard and directed literal checks
module tb_coef_run_expander;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [9:0] in_size = 0;
  logic [7:0] in_val = 0;
  logic [6:0] in_flag = 0;
  logic in_ready, out_valid, out_last, marker_valid;
  logic [7:0] out_coef;
  logic [5:0] out_idx;
  logic [6:0] marker_pos;
`ifdef COEF_EXP_ERR_EN
  logic err_overflow;
`endif
  typedef logic [14:0] beat_t;
  beat_t exp_q[$];
  logic [6:0] mk_q[$];
  beat_t log_b[1024];
  beat_t held;
  int nb = 0, n_mk = 0, midx = 0, n_chk = 0, n_fail = 0, k = 0;
  bit bp = 0, stall = 0, exp_err = 0;
  logic [3:0] pat = 4'b1001;

  coef_run_expander dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size),
    .in_val(in_val), .in_flag(in_flag), .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_idx(out_idx), .out_last(out_last),
`ifdef COEF_EXP_ERR_EN
    .err_overflow(err_overflow),
`endif
    .marker_valid(marker_valid), .marker_pos(marker_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [9:0] s, input logic [7:0] v, input logic [6:0] f);
    int r = int'(s[9:3]);
    if (r == 0) begin
      if (f != 0) begin
        mk_q.push_back(f);
        if (midx != 0) exp_err = 1;
        midx = 0;
      end else if (midx != 0) begin
        for (int i = midx; i < 64; i++) exp_q.push_back({8'h00, 6'(i), i == 63});
        midx = 0;
      end
    end else begin
      for (int j = 0; j < r - 1; j++) begin
        exp_q.push_back({8'h00, 6'(midx), midx == 63});
        if (midx == 63) begin
          midx = 0;
          exp_err = 1;
          return;
        end
        midx++;
      end
      exp_q.push_back({v, 6'(midx), midx == 63});
      midx = (midx + 1) % 64;
    end
  endfunction

  task automatic send(input logic [9:0] s, input logic [7:0] v, input logic [6:0] f);
    int n = 0;
    @(negedge clk);
    in_size = s; in_val = v; in_flag = f; in_valid = 1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 500, 1);
    model(s, v, f);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 3000);
    chk("drain_timeout", n < 3000, 1);
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = bp ? pat[k % 4] : 1'b1;
    k++;
  end

  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_coef, out_idx, out_last}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_beat: got %0h expected none", {out_coef, out_idx, out_last});
        end else chk("beat", {out_coef, out_idx, out_last}, exp_q.pop_front());
        if (nb < 1024) log_b[nb] = {out_coef, out_idx, out_last};
        nb++;
      end
      stall = out_valid && !out_ready;
      held = {out_coef, out_idx, out_last};
      if (marker_valid) begin
        n_mk++;
        if (mk_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_marker: got %0h expected none", marker_pos);
        end else chk("marker_pos", marker_pos, mk_q.pop_front());
      end
    end
  end

  initial begin
    int b, cnt, lasts, m;
    #1 rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coef", out_coef, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_marker", {marker_valid, marker_pos}, 0);
`ifdef COEF_EXP_ERR_EN
    chk("rst_err", err_overflow, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 0;
    b = nb;
    send(24, 8'h05, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      #1 if (!in_ready) cnt++;
    end while (!in_ready && cnt < 50);
    chk("t1_ready_low", cnt, 3);
    drain;
    chk("t1_count", nb - b, 3);
    chk("t1_b0", log_b[b], {8'h00, 6'd0, 1'b0});
    chk("t1_b1", log_b[b+1], {8'h00, 6'd1, 1'b0});
    chk("t1_b2", log_b[b+2], {8'h05, 6'd2, 1'b0});
    send(0, 0, 0);
    drain;
    b = nb;
    send(8, 8'h7F, 0);
    send(0, 0, 0);
    drain;
    chk("t2_count", nb - b, 64);
    chk("t2_first", log_b[b], {8'h7F, 6'd0, 1'b0});
    chk("t2_lastbeat", log_b[b+63], {8'h00, 6'd63, 1'b1});
    lasts = 0;
    for (int i = 0; i < 64; i++) lasts += int'(log_b[b+i][0]);
    chk("t2_last_once", lasts, 1);
    chk("t2_ready_back", in_ready, 1);
    b = nb;
    send(0, 0, 0);
    drain;
    chk("eob_at_0_silent", nb - b, 0);
    bp = 1;
    b = nb;
    send(24, 8'h05, 0);
    drain;
    bp = 0;
    chk("t3_count", nb - b, 3);
    chk("t3_b0", log_b[b], {8'h00, 6'd0, 1'b0});
    chk("t3_b1", log_b[b+1], {8'h00, 6'd1, 1'b0});
    chk("t3_b2", log_b[b+2], {8'h05, 6'd2, 1'b0});
    send(0, 0, 0);
    drain;
    send(480, 8'h44, 0);
    drain;
    b = nb;
    send(64, 8'h66, 0);
    drain;
    chk("t4_count", nb - b, 4);
    chk("t4_first", log_b[b], {8'h00, 6'd60, 1'b0});
    chk("t4_lastbeat", log_b[b+3], {8'h00, 6'd63, 1'b1});
`ifdef COEF_EXP_ERR_EN
    chk("t4_err", err_overflow, 1);
`endif
    b = nb;
    send(8, 8'h11, 0);
    drain;
    chk("t4_next", log_b[b], {8'h11, 6'd0, 1'b0});
    send(80, 8'h22, 0);
    drain;
    m = n_mk;
    send(0, 0, 7'h2A);
    drain;
    chk("t5_pulses", n_mk - m, 1);
    chk("t5_pos_held", marker_pos, 7'h2A);
    b = nb;
    send(16, 8'h33, 0);
    drain;
    chk("t5_b0", log_b[b], {8'h00, 6'd0, 1'b0});
    chk("t5_b1", log_b[b+1], {8'h33, 6'd1, 1'b0});
`ifdef COEF_EXP_ERR_EN
    chk("err_sticky", err_overflow, exp_err);
`endif
    send(24, 8'h05, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_idx", out_idx, 0);
    chk("t6_mpos", marker_pos, 0);
    exp_q.delete();
    midx = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 0;
    b = nb;
    send(24, 8'h05, 0);
    drain;
    chk("t6_count", nb - b, 3);
    chk("t6_b0", log_b[b], {8'h00, 6'd0, 1'b0});
    chk("t6_b2", log_b[b+2], {8'h05, 6'd2, 1'b0});
    chk("exp_empty", exp_q.size(), 0);
    chk("mk_empty", mk_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
